// File: rtl/mydesign_arb_pkg.sv
// Shared types and defaults for the round-robin datapath arbiter.
// Latency: n/a. Backpressure: n/a.
package mydesign_arb_pkg;

    localparam int unsigned DEF_N_REQ = 4;
    localparam int unsigned DEF_N_IN  = 3;
    localparam int unsigned DEF_N_OUT = 3;
    localparam int unsigned DEF_CNT_W = 16;

    typedef enum logic {ST_EMPTY, ST_FULL} arb_state_e;

    function automatic int unsigned id_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mydesign_arbiter_if.sv
// Requester operand bundle plus the tagged response channel.
// Latency: n/a. Backpressure: valid/ready on both sides.
interface mydesign_arbiter_if
    import mydesign_arb_pkg::*;
#(
    parameter int unsigned N_REQ = DEF_N_REQ,
    parameter int unsigned N_IN  = DEF_N_IN,
    parameter int unsigned N_OUT = DEF_N_OUT
) ();
    localparam int unsigned IDW = id_width(N_REQ);

    logic [N_REQ-1:0]           req_valid_i;
    logic [N_REQ-1:0]           req_ready_o;
    logic [N_REQ-1:0][N_IN-1:0] req_a_i;
    logic [N_REQ-1:0][N_IN-1:0] req_b_i;
    logic                       rsp_valid_o;
    logic                       rsp_ready_i;
    logic [N_OUT-1:0]           rsp_result_o;
    logic [IDW-1:0]             rsp_id_o;

    modport master (
        output req_valid_i, req_a_i, req_b_i, rsp_ready_i,
        input  req_ready_o, rsp_valid_o, rsp_result_o, rsp_id_o
    );

    modport slave (
        input  req_valid_i, req_a_i, req_b_i, rsp_ready_i,
        output req_ready_o, rsp_valid_o, rsp_result_o, rsp_id_o
    );
endinterface

// File: rtl/mydesign_comb.sv
// Characterised combinational datapath: (a + b) xor (a >> 1), truncated to N_OUT.
// Latency: 0 cycles. Backpressure: none.
module mydesign_comb #(
    parameter int unsigned N_IN  = 3,
    parameter int unsigned N_OUT = 3
) (
    input  logic [N_IN-1:0]  a_i,
    input  logic [N_IN-1:0]  b_i,
    output logic [N_OUT-1:0] y_o
);
    logic [N_IN:0] sum;
    logic [N_IN:0] mix;

    assign sum = {1'b0, a_i} + {1'b0, b_i};
    assign mix = sum ^ {2'b00, a_i[N_IN-1:1]};
    assign y_o = N_OUT'(mix);
endmodule

// File: rtl/mydesign_rr_arbiter.sv
// Round-robin pick starting at ptr; ptr moves past the winner on every grant.
// Latency: 0 cycles (grant is combinational). Backpressure: no grant while can_accept_i is low.
module mydesign_rr_arbiter
    import mydesign_arb_pkg::*;
#(
    parameter int unsigned N_REQ = DEF_N_REQ,
    localparam int unsigned IDW  = id_width(N_REQ)
) (
    input  logic             clk_ci,
    input  logic             rst_ni,
    input  logic [N_REQ-1:0] valid_i,
    input  logic             can_accept_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [IDW-1:0]   win_o
);
    logic [IDW-1:0] ptr_q;
    logic           found;
    int unsigned    idx;
    logic [IDW-1:0] cand;

    always_comb begin
        found = 1'b0;
        win_o = '0;
        gnt_o = '0;
        idx   = 0;
        cand  = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            idx = 32'(ptr_q) + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            cand = IDW'(idx);
            if (!found && valid_i[cand]) begin
                found = 1'b1;
                win_o = cand;
            end
        end
        if (can_accept_i && found) gnt_o[win_o] = 1'b1;
    end

    always_ff @(posedge clk_ci or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else if (can_accept_i && found) begin
            ptr_q <= (win_o == IDW'(N_REQ - 1)) ? '0 : win_o + 1'b1;
        end
    end
endmodule

// File: rtl/mydesign_arbiter.sv
// N_REQ requesters share one mydesign_comb through a round-robin pick; MYDESIGN_ARB_STATS_EN adds busy/stall counters.
// Latency: 1 cycle into a single response register. Backpressure: rsp_ready_i low while FULL stalls every requester.
module mydesign_arbiter
    import mydesign_arb_pkg::*;
#(
    parameter int unsigned N_REQ = DEF_N_REQ,
    parameter int unsigned N_IN  = DEF_N_IN,
    parameter int unsigned N_OUT = DEF_N_OUT,
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic              clk_ci,
    input  logic              rst_ni,
    mydesign_arbiter_if.slave bus,
    output logic [CNT_W-1:0]  busy_cnt_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);
    localparam int unsigned IDW = id_width(N_REQ);

    arb_state_e       state_q, state_d;
    logic             can_accept;
    logic             hs;
    logic [N_REQ-1:0] gnt;
    logic [IDW-1:0]   win;
    logic [N_IN-1:0]  mux_a, mux_b;
    logic [N_OUT-1:0] comb_y;
    logic [N_OUT-1:0] result_q;
    logic [IDW-1:0]   id_q;

    // Reset gates acceptance so no ready leaks out while rst_ni is low.
    assign can_accept = rst_ni && ((state_q == ST_EMPTY) || bus.rsp_ready_i);

    mydesign_rr_arbiter #(.N_REQ(N_REQ)) u_rr (
        .clk_ci       (clk_ci),
        .rst_ni       (rst_ni),
        .valid_i      (bus.req_valid_i),
        .can_accept_i (can_accept),
        .gnt_o        (gnt),
        .win_o        (win)
    );

    assign bus.req_ready_o = gnt;
    assign hs              = |gnt;

    always_comb begin
        mux_a = '0;
        mux_b = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (gnt[i]) begin
                mux_a = mux_a | bus.req_a_i[i];
                mux_b = mux_b | bus.req_b_i[i];
            end
        end
    end

    (* dont_touch = "true" *)
    mydesign_comb #(.N_IN(N_IN), .N_OUT(N_OUT)) u_comb (
        .a_i (mux_a),
        .b_i (mux_b),
        .y_o (comb_y)
    );

    always_ff @(posedge clk_ci or negedge rst_ni) begin
        if (!rst_ni) state_q <= ST_EMPTY;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (hs) state_d = ST_FULL;
            ST_FULL:  if (bus.rsp_ready_i && !hs) state_d = ST_EMPTY;
            default:  state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk_ci or negedge rst_ni) begin
        if (!rst_ni) begin
            result_q <= '0;
            id_q     <= '0;
        end else if (hs) begin
            result_q <= comb_y;
            id_q     <= win;
        end
    end

    assign bus.rsp_valid_o  = (state_q == ST_FULL);
    assign bus.rsp_result_o = result_q;
    assign bus.rsp_id_o     = id_q;

`ifdef MYDESIGN_ARB_STATS_EN
    logic [CNT_W-1:0] busy_q, stall_q;

    always_ff @(posedge clk_ci or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q  <= '0;
            stall_q <= '0;
        end else if (state_q == ST_FULL) begin
            if (busy_q != '1) busy_q <= busy_q + CNT_W'(1);
            if (!bus.rsp_ready_i && stall_q != '1) stall_q <= stall_q + CNT_W'(1);
        end
    end

    assign busy_cnt_o  = busy_q;
    assign stall_cnt_o = stall_q;
`else
    assign busy_cnt_o  = '0;
    assign stall_cnt_o = '0;
`endif
endmodule

// File: tb/tb_mydesign_arbiter.sv
// Table of per-cycle grant vectors plus a response scoreboard for mydesign_arbiter.
module tb_mydesign_arbiter;
    localparam int unsigned N_REQ = 4;
    localparam int unsigned N_IN  = 3;
    localparam int unsigned N_OUT = 3;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned IDW   = 2;
    localparam int unsigned CMAX  = (1 << CNT_W) - 1;
    localparam int          NVEC  = 24;

    typedef struct packed {
        logic       do_rst;
        logic [3:0] vld;
        logic       rdy;
        logic [3:0] gnt;
    } vec_t;

    typedef struct packed {
        logic [IDW-1:0]   id;
        logic [N_OUT-1:0] res;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_ni;
    logic [CNT_W-1:0] busy_cnt, stall_cnt;

    vec_t             tbl [NVEC];
    exp_t             q [$];
    logic [N_IN-1:0]  op_a [N_REQ];
    logic [N_IN-1:0]  op_b [N_REQ];
    logic             model_full;
    int unsigned      busy_m, stall_m;
    int               n_chk = 0;
    int               n_err = 0;

    mydesign_arbiter_if #(.N_REQ(N_REQ), .N_IN(N_IN), .N_OUT(N_OUT)) bus_if ();

    mydesign_arbiter #(.N_REQ(N_REQ), .N_IN(N_IN), .N_OUT(N_OUT), .CNT_W(CNT_W)) dut (
        .clk_ci      (clk),
        .rst_ni      (rst_ni),
        .bus         (bus_if),
        .busy_cnt_o  (busy_cnt),
        .stall_cnt_o (stall_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [N_OUT-1:0] golden(input logic [N_IN-1:0] a, input logic [N_IN-1:0] b);
        logic [3:0] s;
        s = 4'(a) + 4'(b);
        return N_OUT'(s ^ 4'(a >> 1));
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_cnt();
`ifdef MYDESIGN_ARB_STATS_EN
        chk("busy_cnt", 32'(busy_cnt), busy_m);
        chk("stall_cnt", 32'(stall_cnt), stall_m);
`else
        chk("busy_cnt", 32'(busy_cnt), 32'd0);
        chk("stall_cnt", 32'(stall_cnt), 32'd0);
`endif
    endtask

    // Entered and left at a falling edge; one call is one clock cycle.
    task automatic step(input logic do_rst, input logic [3:0] vld, input logic rdy, input logic [3:0] gnt);
        exp_t e;
        bus_if.req_valid_i = vld;
        bus_if.rsp_ready_i = rdy;
        for (int i = 0; i < N_REQ; i++) begin
            bus_if.req_a_i[i] = op_a[i];
            bus_if.req_b_i[i] = op_b[i];
        end
        if (do_rst) begin
            rst_ni = 1'b0;
            #1;
            chk("rst_rsp_valid", 32'(bus_if.rsp_valid_o), 32'd0);
            chk("rst_rsp_result", 32'(bus_if.rsp_result_o), 32'd0);
            chk("rst_rsp_id", 32'(bus_if.rsp_id_o), 32'd0);
            chk("rst_req_ready", 32'(bus_if.req_ready_o), 32'd0);
            q.delete();
            model_full = 1'b0;
            busy_m     = 0;
            stall_m    = 0;
            @(posedge clk);
            @(negedge clk);
            rst_ni = 1'b1;
        end
        #1;
        chk("req_ready", 32'(bus_if.req_ready_o), 32'(gnt));
        chk("rsp_valid", 32'(bus_if.rsp_valid_o), 32'(model_full));
        chk_cnt();
        if (model_full) begin
            if (q.size() == 0) begin
                chk("sb_underflow", 32'(q.size()), 32'd1);
            end else begin
                chk("rsp_id", 32'(bus_if.rsp_id_o), 32'(q[0].id));
                chk("rsp_result", 32'(bus_if.rsp_result_o), 32'(q[0].res));
                if (rdy) void'(q.pop_front());
            end
        end
        if (gnt != 4'b0000) begin
            e = '0;
            for (int i = 0; i < N_REQ; i++)
                if (gnt[i]) e = '{id: IDW'(i), res: golden(op_a[i], op_b[i])};
            q.push_back(e);
        end
        if (model_full && busy_m < CMAX) busy_m++;
        if (model_full && !rdy && stall_m < CMAX) stall_m++;
        model_full = (gnt != 4'b0000) || (model_full && !rdy);
        // Operands change only when the requester is idle or has just been served.
        for (int i = 0; i < N_REQ; i++) begin
            if (!vld[i] || gnt[i]) begin
                op_a[i] = N_IN'($urandom_range(0, 7));
                op_b[i] = N_IN'($urandom_range(0, 7));
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        tbl[0]  = '{1'b0, 4'b0100, 1'b1, 4'b0100};  // single request from req 2
        tbl[1]  = '{1'b0, 4'b0000, 1'b1, 4'b0000};
        tbl[2]  = '{1'b0, 4'b0011, 1'b0, 4'b0001};  // ptr=3 wraps to req 0
        tbl[3]  = '{1'b0, 4'b0011, 1'b0, 4'b0000};
        tbl[4]  = '{1'b1, 4'b1111, 1'b1, 4'b0001};  // reset while FULL, then req 0 first
        tbl[5]  = '{1'b0, 4'b1111, 1'b1, 4'b0010};
        tbl[6]  = '{1'b0, 4'b1111, 1'b1, 4'b0100};
        tbl[7]  = '{1'b0, 4'b1111, 1'b1, 4'b1000};
        tbl[8]  = '{1'b0, 4'b1111, 1'b1, 4'b0001};
        tbl[9]  = '{1'b0, 4'b1111, 1'b1, 4'b0010};
        tbl[10] = '{1'b0, 4'b1111, 1'b1, 4'b0100};
        tbl[11] = '{1'b0, 4'b1111, 1'b1, 4'b1000};
        tbl[12] = '{1'b0, 4'b0001, 1'b1, 4'b0001};
        tbl[13] = '{1'b0, 4'b0001, 1'b1, 4'b0001};  // ptr=1, only req 0 valid
        tbl[14] = '{1'b0, 4'b0010, 1'b0, 4'b0000};  // backpressure x5
        tbl[15] = '{1'b0, 4'b0010, 1'b0, 4'b0000};
        tbl[16] = '{1'b0, 4'b0010, 1'b0, 4'b0000};
        tbl[17] = '{1'b0, 4'b0010, 1'b0, 4'b0000};
        tbl[18] = '{1'b0, 4'b0010, 1'b0, 4'b0000};
        tbl[19] = '{1'b0, 4'b0010, 1'b1, 4'b0010};  // drain and grant together
        tbl[20] = '{1'b0, 4'b0000, 1'b1, 4'b0000};
        tbl[21] = '{1'b0, 4'b1010, 1'b1, 4'b1000};
        tbl[22] = '{1'b0, 4'b1010, 1'b1, 4'b0010};
        tbl[23] = '{1'b0, 4'b0000, 1'b1, 4'b0000};

        for (int i = 0; i < N_REQ; i++) begin
            op_a[i] = N_IN'(i);
            op_b[i] = N_IN'(i + 1);
        end
        op_a[2] = 3'd3;
        op_b[2] = 3'd2;
        model_full = 1'b0;
        busy_m     = 0;
        stall_m    = 0;

        rst_ni             = 1'b0;
        bus_if.req_valid_i = '0;
        bus_if.rsp_ready_i = 1'b0;
        bus_if.req_a_i     = '0;
        bus_if.req_b_i     = '0;
        #1;
        chk("por_rsp_valid", 32'(bus_if.rsp_valid_o), 32'd0);
        chk("por_req_ready", 32'(bus_if.req_ready_o), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_ni = 1'b1;

        for (int v = 0; v < NVEC; v++)
            step(tbl[v].do_rst, tbl[v].vld, tbl[v].rdy, tbl[v].gnt);

        // Long stall to saturate the statistics counters.
        step(1'b0, 4'b0001, 1'b0, 4'b0001);
        for (int s = 0; s < 20; s++)
            step(1'b0, 4'b0000, 1'b0, 4'b0000);
`ifdef MYDESIGN_ARB_STATS_EN
        chk("stall_sat", 32'(stall_cnt), CMAX);
        chk("busy_sat", 32'(busy_cnt), CMAX);
`else
        chk("stall_off", 32'(stall_cnt), 32'd0);
        chk("busy_off", 32'(busy_cnt), 32'd0);
`endif
        step(1'b0, 4'b0000, 1'b1, 4'b0000);
        step(1'b0, 4'b0000, 1'b1, 4'b0000);
        chk("sb_empty", 32'(q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/mydesign_arbiter.md
# mydesign_arbiter

Round-robin arbiter sharing a single `mydesign_comb` instance between `N_REQ` requesters. Each requester offers an operand pair over a valid/ready handshake. One pair per cycle is granted and evaluated. The result goes into a single registered output stage, tagged with the requester index and subject to downstream backpressure. The block sits where the registered datapath top sits today, giving multiple agents access to one characterised datapath.

## Interface
- `N_REQ`, default 4: number of requesters; must be ≥ 2.
- `N_IN`, default 3: operand width.
- `N_OUT`, default 3: result width.
- `CNT_W`, default 16: statistics counter width.
- `IDW`, derived, equals `$clog2(N_REQ)`: requester id width.
- `clk_ci`, in, 1: clock.
- `rst_ni`, in, 1: reset, asynchronous, active-low.
- `req_valid_i`, in, `[N_REQ]`: requester i offers an operand pair.
- `req_ready_o`, out, `[N_REQ]`: grant/accept for requester i.
- `req_a_i`, in, `[N_REQ][N_IN]`: operand A per requester.
- `req_b_i`, in, `[N_REQ][N_IN]`: operand B per requester.
- `rsp_valid_o`, out, 1: response register holds a result.
- `rsp_ready_i`, in, 1: downstream accepts the response.
- `rsp_result_o`, out, `N_OUT`: registered `mydesign_comb` result.
- `rsp_id_o`, out, `IDW`: index of the requester that produced the result.
- `busy_cnt_o`, out, `CNT_W`: statistics; see Configuration.
- `stall_cnt_o`, out, `CNT_W`: statistics; see Configuration.

## Operation
- **Output stage FSM, two states:**
  - EMPTY: `rsp_valid_o`=0.
  - FULL: `rsp_valid_o`=1.
  - Transitions:
    - EMPTY→FULL on grant.
    - FULL→EMPTY on drain (`rsp_ready_i`=1) with no grant.
    - FULL→FULL on drain plus grant (back-to-back), or on no drain.
- **Accept condition:** `can_accept` = EMPTY, or (FULL and `rsp_ready_i`).
- **Round-robin pick:**
  - A pointer `ptr` names the highest-priority requester.
  - Search order is `ptr`, `ptr+1`, … mod `N_REQ`.
  - The first requester with `req_valid_i` set wins.
- **Grant:**
  - `req_ready_o[i]` = `can_accept` and (winner == i).
  - At most one bit of `req_ready_o` is set.
  - `req_ready_o` may depend combinationally on `req_valid_i` and `rsp_ready_i`.
- **On handshake of winner w:**
  - `mydesign_comb` is fed `req_a_i[w]` and `req_b_i[w]` through a one-hot mux.
  - Its output is captured into `rsp_result_o`.
  - `w` is captured into `rsp_id_o`.
  - `ptr` ← (w+1) mod `N_REQ`.
- **No grant:** `ptr` holds; the response register holds its value while FULL and not drained.
- **Requester rules:**
  - Operands must be stable while valid and not ready.
  - A requester may deassert valid without a handshake; it simply loses its turn.
- **Datapath:** `mydesign_comb` is instantiated exactly once with the `dont_touch` attribute. It must not be flattened into the mux logic.
- **Reset (async, any time):**
  - FSM → EMPTY.
  - `rsp_valid_o` → 0, `rsp_result_o` → 0, `rsp_id_o` → 0.
  - `ptr` → 0.
  - Counters → 0.
  - An in-flight response is dropped. No `req_ready_o` is asserted while `rst_ni`=0.

## Timing
- **Latency:** 1 cycle. A handshake at edge k gives `rsp_valid_o`=1 with the result after edge k.
- **Throughput:** 1 result/cycle with `rsp_ready_i` held high.
- **Backpressure:** `rsp_ready_i`=0 while FULL stalls all requesters. No result is ever overwritten or lost.
- **Fairness:** with all requesters continuously valid, grants rotate 0,1,…,N_REQ−1,0. Any valid requester waits at most `N_REQ`−1 grants.
- **Critical path:** `req_valid_i` → pick → mux → `mydesign_comb` → response register.

## Configuration
- **With `MYDESIGN_ARB_STATS_EN` defined:**
  - `busy_cnt_o` increments each cycle `rsp_valid_o`=1.
  - `stall_cnt_o` increments each cycle `rsp_valid_o`=1 and `rsp_ready_i`=0.
  - Both saturate at all-ones and never wrap.
  - Both reset to 0.
- **Without the macro:** both ports are tied to 0 and no counter flops exist.

## Structure
- **Package `mydesign_arb_pkg`:**
  - FSM state enum `{ST_EMPTY, ST_FULL}`.
  - Id-width helper function.
  - Default parameter constants.
- **Sub-module `mydesign_rr_arbiter`:**
  - Holds `ptr` and the round-robin pick logic.
  - Inputs: valid vector and `can_accept`.
  - Outputs: one-hot grant and binary winner index.
- **Top:** the top owns the FSM, the operand mux, the `mydesign_comb` instance, the response register and the statistics.

## Test plan
- **Reset:**
  - Stimulus: assert `rst_ni`=0 mid-stream while FULL.
  - Required: `rsp_valid_o`=0, `rsp_result_o`=0, `rsp_id_o`=0 immediately (asynchronously). After release, the first grant goes to requester 0.
- **Single request:**
  - Stimulus: req 2 valid with a=3, b=2; `rsp_ready_i`=1.
  - Required: `req_ready_o`=4'b0100 for 1 cycle. Next cycle `rsp_valid_o`=1, `rsp_id_o`=2, and `rsp_result_o` equals the standalone `mydesign_comb`(3,2) golden model.
- **Fairness:**
  - Stimulus: all 4 requesters valid continuously for 8 cycles with `rsp_ready_i`=1.
  - Required: `rsp_id_o` sequence 0,1,2,3,0,1,2,3 and 8 results, one per cycle.
- **Backpressure:**
  - Stimulus: FULL with `rsp_ready_i`=0 for 5 cycles, req 1 valid.
  - Required: `req_ready_o`=0 throughout and response stable. When `rsp_ready_i` rises, drain and grant req 1 in the same cycle.
- **Pointer skip:**
  - Stimulus: `ptr`=1, only req 0 valid.
  - Required: req 0 granted and `ptr` becomes 1.
- **Statistics (`MYDESIGN_ARB_STATS_EN`, `CNT_W`=4):**
  - Stimulus: 20 stalled FULL cycles.
  - Required: `stall_cnt_o`=15 (saturated), `busy_cnt_o`=15. Without the macro both read 0.
